// File: rtl/sevenseg_scan_reader.sv
// -----------------------------------------------------------------------------
// sevenseg_scan_reader
//
// Reads back a multiplexed, active-low seven-segment bus. Each scanned digit is
// debounced, its segment pattern is decoded back to BCD, and the result is held
// per digit position. Blank and illegal patterns are flagged. A one-cycle frame
// pulse marks the moment every position has been refreshed since the last pulse.
//
// Parameters:
//   DIGITS        number of multiplexed digit positions (>= 1)
//   STABLE_CYCLES identical one-hot samples required before a commit (>= 2)
//
// Ports:
//   clk          sole clock, rising edge
//   rst          synchronous, active-high reset
//   seg[6:0]     active-low segments, seg[6]=a ... seg[0]=g
//   dig_en       digit select, one-hot or zero when legal
//   bcd_out      committed BCD, position i in bits [4i+3:4i]
//   blank        position i last committed the all-off pattern
//   invalid      position i last committed an undecodable pattern
//   frame_valid  one-cycle pulse when every position has been committed
//   bus_err      registered pulse for each sampled multi-hot dig_en
// -----------------------------------------------------------------------------
module sevenseg_scan_reader #(
  parameter int DIGITS        = 4,
  parameter int STABLE_CYCLES = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [6:0]            seg,
  input  logic [DIGITS-1:0]     dig_en,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic [DIGITS-1:0]     blank,
  output logic [DIGITS-1:0]     invalid,
  output logic                  frame_valid,
  output logic                  bus_err
);

  localparam int              CNT_W   = $clog2(STABLE_CYCLES + 1);
  localparam int              SMP_W   = DIGITS + 7;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);

  typedef enum logic {
    ST_WAIT,
    ST_HELD
  } state_e;

  // Decoded pattern: {blank, invalid, bcd[3:0]}
  function automatic logic [5:0] decode_seg(input logic [6:0] s);
    logic [5:0] r;
    case (s)
      7'b0000001: r = {2'b00, 4'd0};
      7'b1001111: r = {2'b00, 4'd1};
      7'b0010010: r = {2'b00, 4'd2};
      7'b0000110: r = {2'b00, 4'd3};
      7'b1001100: r = {2'b00, 4'd4};
      7'b0100100: r = {2'b00, 4'd5};
      7'b0100000: r = {2'b00, 4'd6};
      7'b0001111: r = {2'b00, 4'd7};
      7'b0000000: r = {2'b00, 4'd8};
      7'b0000100: r = {2'b00, 4'd9};
      7'b1111111: r = {2'b10, 4'hF};
      default:    r = {2'b01, 4'hE};
    endcase
    return r;
  endfunction

  state_e              state_q, state_d;
  logic [SMP_W-1:0]    sample_q, sample_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [4*DIGITS-1:0] bcd_q, bcd_d;
  logic [DIGITS-1:0]   blank_q, blank_d;
  logic [DIGITS-1:0]   invalid_q, invalid_d;
  logic [DIGITS-1:0]   seen_q, seen_d;
  logic                frame_valid_q, frame_valid_d;
  logic                bus_err_q, bus_err_d;

  logic                in_multi_hot;
  logic                in_one_hot;
  logic                changed;
  logic                commit;
  logic [DIGITS-1:0]   smp_en;
  logic [6:0]          smp_seg;
  logic [5:0]          dec;

  // x & (x-1) clears the lowest set bit; anything left means two or more bits.
  assign in_multi_hot = (dig_en & (dig_en - DIGITS'(1))) != '0;
  assign in_one_hot   = (dig_en != '0) && !in_multi_hot;

  assign smp_en  = sample_q[SMP_W-1:7];
  assign smp_seg = sample_q[6:0];
  assign dec     = decode_seg(smp_seg);

  // ---------------------------------------------------------------------------
  // Sampling and stability counter
  // ---------------------------------------------------------------------------
  // NOTE: every output of an always_comb gets a default first; a path that
  // leaves a signal unassigned would infer a latch.
  always_comb begin
    sample_d  = {dig_en, seg};
    changed   = (sample_d != sample_q);
    cnt_d     = cnt_q;
    bus_err_d = in_multi_hot;
    if (!in_one_hot) begin
      // Scan gaps and multi-hot selects never build toward a commit.
      cnt_d = '0;
    end else if (changed) begin
      cnt_d = CNT_W'(1);
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Commit FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    commit  = 1'b0;
    case (state_q)
      ST_WAIT: begin
        if (cnt_q == CNT_MAX) begin
          commit = 1'b1;
          // If the bus already moved on this edge, the new pattern must be
          // counted from scratch rather than parked in HELD.
          state_d = changed ? ST_WAIT : ST_HELD;
        end
      end
      ST_HELD: begin
        if (changed) state_d = ST_WAIT;
      end
      default: state_d = ST_WAIT;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Per-position result registers and frame tracking
  // ---------------------------------------------------------------------------
  always_comb begin
    bcd_d         = bcd_q;
    blank_d       = blank_q;
    invalid_d     = invalid_q;
    seen_d        = seen_q;
    frame_valid_d = 1'b0;
    if (commit) begin
      // A non-zero count implies the held select is one-hot.
      for (int i = 0; i < DIGITS; i++) begin
        if (smp_en[i]) begin
          bcd_d[4*i +: 4] = dec[3:0];
          blank_d[i]      = dec[5];
          invalid_d[i]    = dec[4];
        end
      end
      seen_d = seen_q | smp_en;
      if (&seen_d) begin
        frame_valid_d = 1'b1;
        seen_d        = '0;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the values from before the edge, independent of statement order.
  // NOTE: the per-position result registers are reset too; a read-back of an
  // untouched position must report blank rather than stale data.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_WAIT;
      sample_q      <= '0;
      cnt_q         <= '0;
      bcd_q         <= '1;
      blank_q       <= '1;
      invalid_q     <= '0;
      seen_q        <= '0;
      frame_valid_q <= 1'b0;
      bus_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      sample_q      <= sample_d;
      cnt_q         <= cnt_d;
      bcd_q         <= bcd_d;
      blank_q       <= blank_d;
      invalid_q     <= invalid_d;
      seen_q        <= seen_d;
      frame_valid_q <= frame_valid_d;
      bus_err_q     <= bus_err_d;
    end
  end

  assign bcd_out     = bcd_q;
  assign blank       = blank_q;
  assign invalid     = invalid_q;
  assign frame_valid = frame_valid_q;
  assign bus_err     = bus_err_q;

endmodule

// File: tb/tb_sevenseg_scan_reader.sv
// -----------------------------------------------------------------------------
// tb_sevenseg_scan_reader
//
// Directed scenarios followed by randomized scan traffic. Expected outputs come
// from a reference model that works on the sample history: each maximal run of
// identical one-hot samples that reaches STABLE samples yields exactly one
// commit, visible after the edge following its STABLE-th sample.
// -----------------------------------------------------------------------------
module tb_sevenseg_scan_reader;

  localparam int DIGITS = 4;
  localparam int STABLE = 3;

  logic                clk = 1'b0;
  logic                rst;
  logic [6:0]          seg;
  logic [DIGITS-1:0]   dig_en;
  logic [4*DIGITS-1:0] bcd_out;
  logic [DIGITS-1:0]   blank;
  logic [DIGITS-1:0]   invalid;
  logic                frame_valid;
  logic                bus_err;

  sevenseg_scan_reader #(
    .DIGITS        (DIGITS),
    .STABLE_CYCLES (STABLE)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .seg         (seg),
    .dig_en      (dig_en),
    .bcd_out     (bcd_out),
    .blank       (blank),
    .invalid     (invalid),
    .frame_valid (frame_valid),
    .bus_err     (bus_err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int frame_cnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Segment patterns of digits 0..9, active low, a..g from MSB.
  logic [6:0] seg_tab [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                               7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                               7'b0000000, 7'b0000100};

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  logic [3:0]  m_bcd   [DIGITS];
  bit          m_blank [DIGITS];
  bit          m_inv   [DIGITS];
  bit          m_seen  [DIGITS];
  bit          m_frame;
  bit          m_buserr;
  logic [10:0] hist [$];
  bit          pend;
  logic [10:0] pend_s;

  task automatic model_reset();
    for (int i = 0; i < DIGITS; i++) begin
      m_bcd[i] = 4'hF; m_blank[i] = 1'b1; m_inv[i] = 1'b0; m_seen[i] = 1'b0;
    end
    m_frame = 1'b0; m_buserr = 1'b0; pend = 1'b0;
    hist.delete();
  endtask

  task automatic model_edge(input logic r, input logic [DIGITS-1:0] en, input logic [6:0] sg);
    int  n;
    bit  all_seen;
    bit  run_ok;
    if (r) begin
      model_reset();
      return;
    end
    m_frame = 1'b0;
    if (pend) begin
      for (int p = 0; p < DIGITS; p++) begin
        if (pend_s[7+p]) begin
          m_bcd[p] = 4'hE; m_blank[p] = 1'b0; m_inv[p] = 1'b1;
          if (pend_s[6:0] == 7'h7F) begin
            m_bcd[p] = 4'hF; m_blank[p] = 1'b1; m_inv[p] = 1'b0;
          end
          for (int d = 0; d < 10; d++) begin
            if (seg_tab[d] == pend_s[6:0]) begin
              m_bcd[p] = 4'(d); m_blank[p] = 1'b0; m_inv[p] = 1'b0;
            end
          end
          m_seen[p] = 1'b1;
        end
      end
      all_seen = 1'b1;
      for (int p = 0; p < DIGITS; p++) all_seen &= m_seen[p];
      if (all_seen) begin
        m_frame = 1'b1;
        for (int p = 0; p < DIGITS; p++) m_seen[p] = 1'b0;
      end
    end
    m_buserr = ($countones(en) > 1);
    hist.push_back({en, sg});
    if (hist.size() > STABLE + 1) void'(hist.pop_front());
    pend = 1'b0;
    n = hist.size();
    if (n >= STABLE && $countones(en) == 1) begin
      run_ok = 1'b1;
      for (int k = n - STABLE; k < n; k++) run_ok &= (hist[k] == hist[n-1]);
      // The run must start exactly STABLE samples ago (the sample register
      // holds zero right after reset, which differs from any one-hot sample).
      if (n > STABLE) run_ok &= (hist[n-STABLE-1] != hist[n-1]);
      if (run_ok) begin
        pend   = 1'b1;
        pend_s = hist[n-1];
      end
    end
  endtask

  task automatic compare_all();
    logic [4*DIGITS-1:0] e_bcd;
    logic [DIGITS-1:0]   e_blank, e_inv;
    for (int i = 0; i < DIGITS; i++) begin
      e_bcd[4*i +: 4] = m_bcd[i];
      e_blank[i]      = m_blank[i];
      e_inv[i]        = m_inv[i];
    end
    check("bcd_out", 32'(bcd_out), 32'(e_bcd));
    check("blank", 32'(blank), 32'(e_blank));
    check("invalid", 32'(invalid), 32'(e_inv));
    check("frame_valid", 32'(frame_valid), 32'(m_frame));
    check("bus_err", 32'(bus_err), 32'(m_buserr));
  endtask

  // One clock: drive, let the edge happen, advance the model, compare.
  task automatic cycle(input logic r, input logic [DIGITS-1:0] en, input logic [6:0] sg);
    rst = r; dig_en = en; seg = sg;
    @(posedge clk);
    model_edge(r, en, sg);
    #1;
    compare_all();
    if (frame_valid === 1'b1) frame_cnt++;
  endtask

  task automatic hold(input int pos, input logic [6:0] sg, input int n);
    for (int k = 0; k < n; k++) cycle(1'b0, DIGITS'(1) << pos, sg);
  endtask

  task automatic gap(input int n);
    for (int k = 0; k < n; k++) cycle(1'b0, '0, 7'h7F);
  endtask

  task automatic do_reset(input int n);
    for (int k = 0; k < n; k++) cycle(1'b1, '0, 7'h7F);
  endtask

  int digs [4] = '{3, 7, 0, 9};

  initial begin
    logic [DIGITS-1:0] en;
    logic [6:0]        sg;
    logic [DIGITS-1:0] prev_en;
    logic [6:0]        prev_sg;
    int                len;
    int                pick;

    rst = 1'b1; dig_en = '0; seg = 7'h7F;
    model_reset();

    // Reset values
    do_reset(2);
    frame_cnt = 0;
    gap(10);
    check("rst_bcd", 32'(bcd_out), 32'hFFFF);
    check("rst_blank", 32'(blank), 32'hF);
    check("rst_invalid", 32'(invalid), 32'h0);
    check("rst_no_frame", 32'(frame_cnt), 32'd0);

    // Full frame: 3,7,0,9 on positions 0..3
    frame_cnt = 0;
    for (int p = 0; p < 4; p++) begin
      hold(p, seg_tab[digs[p]], 5);
      gap(1);
    end
    check("frame_bcd", 32'(bcd_out), 32'h9073);
    check("frame_blank", 32'(blank), 32'h0);
    check("frame_once", 32'(frame_cnt), 32'd1);

    // Short pulse dropped, then exactly STABLE samples commit
    hold(1, seg_tab[2], 2);
    gap(3);
    check("short_drop", 32'(bcd_out[7:4]), 32'd7);
    hold(1, seg_tab[2], 3);
    cycle(1'b0, '0, 7'h7F);
    check("short_commit", 32'(bcd_out[7:4]), 32'd2);

    // Blank then illegal on position 2
    hold(2, 7'b1111111, 4);
    gap(1);
    check("blank_bcd", 32'(bcd_out[11:8]), 32'hF);
    check("blank_flag", 32'(blank[2]), 32'd1);
    hold(2, 7'b1110000, 4);
    gap(1);
    check("illegal_bcd", 32'(bcd_out[11:8]), 32'hE);
    check("illegal_flag", 32'(invalid[2]), 32'd1);
    check("illegal_blank", 32'(blank[2]), 32'd0);

    // Bus error: multi-hot for 4 cycles, then a normal commit
    for (int k = 0; k < 4; k++) begin
      cycle(1'b0, 4'b0011, seg_tab[5]);
      check("bus_err_hold", 32'(bus_err), 32'd1);
    end
    gap(1);
    check("bus_err_clear", 32'(bus_err), 32'd0);
    hold(0, seg_tab[5], 4);
    check("after_err_commit", 32'(bcd_out[3:0]), 32'd5);

    // Reset mid-frame discards progress
    do_reset(1);
    frame_cnt = 0;
    for (int p = 0; p < 3; p++) begin
      hold(p, seg_tab[p + 1], 4);
      gap(1);
    end
    do_reset(1);
    hold(3, seg_tab[4], 4);
    gap(1);
    check("rst_mid_no_frame", 32'(frame_cnt), 32'd0);
    for (int p = 0; p < 4; p++) begin
      hold(p, seg_tab[p + 5], 4);
      gap(1);
    end
    check("rst_mid_one_frame", 32'(frame_cnt), 32'd1);

    // Randomized scan traffic
    prev_en = 4'b0001; prev_sg = seg_tab[0];
    for (int r = 0; r < 400; r++) begin
      if ($urandom_range(0, 99) < 2) do_reset(1);
      pick = $urandom_range(0, 99);
      if (pick < 70) begin
        en = DIGITS'(1) << $urandom_range(0, DIGITS - 1);
      end else if (pick < 85) begin
        en = '0;
      end else begin
        en = 4'b0011 << $urandom_range(0, 2);
        if ($urandom_range(0, 1) == 1) en = 4'b1111;
      end
      pick = $urandom_range(0, 99);
      if (pick < 75)      sg = seg_tab[$urandom_range(0, 9)];
      else if (pick < 85) sg = 7'h7F;
      else                sg = 7'($urandom_range(0, 127));
      if ($urandom_range(0, 9) == 0) begin
        en = prev_en; sg = prev_sg;
      end
      len = $urandom_range(1, 6);
      for (int k = 0; k < len; k++) cycle(1'b0, en, sg);
      prev_en = en; prev_sg = sg;
    end
    gap(6);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sevenseg_scan_reader.md
# sevenseg_scan_reader

- Receive-side counterpart of the BCD-to-seven-segment driver in the display path.
- Monitors a multiplexed, active-low seven-segment bus (segment lines plus one-hot digit enables).
- Debounces each scanned digit, decodes its segment pattern back to BCD, holds one BCD value per digit position, and flags blank and illegal patterns.
- Used in self-check and loopback paths to read back what a display driver emits, and to signal when a complete frame (every digit position refreshed) has been captured.

## Interface
Parameters:
- DIGITS, 4, number of multiplexed digit positions (≥1)
- STABLE_CYCLES, 3, consecutive identical samples required before a digit is committed (≥2)

Ports:
- clk  input  1  sole clock; all state updates on rising edge
- rst  input  1  reset, synchronous, active-high
- seg  input  7  active-low segments; seg[6]=a … seg[0]=g
- dig_en  input  DIGITS  digit select; bit i high = position i driven; legal values one-hot or zero
- bcd_out  output  4*DIGITS  committed BCD; position i in bits [4i+3:4i]
- blank  output  DIGITS  position i last committed blank pattern
- invalid  output  DIGITS  position i last committed an illegal pattern
- frame_valid  output  1  one-cycle pulse: every position committed since previous pulse/reset
- bus_err  output  1  registered pulse: multi-hot dig_en sampled

## Operation
Decode map (seg → bcd):
- 0000001→0, 1001111→1, 0010010→2, 0000110→3, 1001100→4
- 0100100→5, 0100000→6, 0001111→7, 0000000→8, 0000100→9
- 1111111 → bcd 4'hF, blank=1, invalid=0
- any other pattern → bcd 4'hE, invalid=1, blank=0
- legal digit → blank=0, invalid=0

Sampling and stability:
- {dig_en, seg} registered every edge into a sample register.
- Saturating counter cnt, width clog2(STABLE_CYCLES+1): increments while the new sample equals the previous one and dig_en is one-hot.
- When the sample changes to a one-hot value, cnt=1; when it changes to zero or multi-hot, cnt=0.
- Zero dig_en (scan gap) is ignored; it never commits and never errors.
- Multi-hot dig_en never commits and raises bus_err.

State machine:
- WAIT: cnt < STABLE_CYCLES. When cnt reaches STABLE_CYCLES, commit the decoded pattern into the selected position (bcd_out, blank, invalid) and set that position's bit in the seen-mask. Go to HELD.
- HELD: no further commits while the sample is unchanged. Any change of the sample returns to WAIT with cnt per the rule above.

Frame tracking:
- When a commit makes seen-mask all ones, frame_valid pulses for one cycle and seen-mask clears to zero.
- Recommitting a position already in the mask overwrites its outputs; the mask is unchanged.
- Illegal and blank commits count toward the frame like legal ones.

Reset:
- Values: bcd_out all 4'hF, blank all 1, invalid all 0, frame_valid 0, bus_err 0, seen-mask 0, cnt 0, sample register 0, state WAIT.
- Asserting rst mid-hold or mid-frame discards all progress.
- Capture restarts from the first edge after rst deasserts.

## Timing
- A pattern applied before edge 1 and held is sampled at edges 1..STABLE_CYCLES; its outputs are visible after edge STABLE_CYCLES+1. With the default, that is after edge 4.
- frame_valid is high in the same cycle that the completing position's new bcd_out first appears.
- bus_err is high in the cycle after each edge that samples multi-hot dig_en; it stays high while multi-hot persists.
- A pattern held for fewer than STABLE_CYCLES samples is dropped, with no output change.
- A glitch between two identical patterns restarts the count, so the pattern is committed a second time.
- Untouched positions keep their values indefinitely.

## Test plan
- **Reset values:** hold rst for 2 cycles, then release with dig_en=0 for 10 cycles → bcd_out=16'hFFFF, blank=4'b1111, invalid=0, frame_valid never high.
- **Full frame:** scan digits 3,7,0,9 on positions 0..3, 5 cycles each with 1-cycle zero gaps → bcd_out=16'h9073 and blank=0 after the last commit. frame_valid pulses exactly once, the cycle bcd_out[15:12] becomes 9.
- **Short pulse:** position 1 holds 0010010 for 2 cycles, then dig_en=0 → no change. Hold it 3 cycles → bcd_out[7:4]=2 after edge 4.
- **Blank and illegal:** position 2 holds 1111111 → bcd_out[11:8]=F, blank[2]=1. Position 2 then holds 1110000 → bcd_out[11:8]=E, invalid[2]=1, blank[2]=0.
- **Bus error:** dig_en=4'b0011 for 4 cycles → bus_err high 4 cycles, no commit, seen-mask unchanged. A subsequent one-hot pattern commits normally.
- **Reset mid-frame:** commit positions 0..2, pulse rst for 1 cycle, then commit position 3 → no frame_valid. A following full scan of all 4 positions yields one frame_valid.
